// File: rtl/pat_match_pkg.sv
// Shared types and default sizing for the serial pattern matcher.
package pat_match_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/pat_match_cnt.sv
// Saturating match counter; a clear that lands on an increment leaves a count of one.
module pat_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pat_match.sv
// Serial bit-stream pattern matcher with programmable length, optional overlap
// and a saturating match counter. The FSM state is visible on armed.
module pat_match
    import pat_match_pkg::*;
#(
    parameter  int PAT_W = DEF_PAT_W,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             valid,
    input  logic             data,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             armed,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);

    state_t           r_state;
    state_t           w_state_next;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_flag;

    logic             w_len_legal;
    logic [LEN_W-1:0] w_len_clamped;
    logic             w_consume;
    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_inc;
    logic [PAT_W-1:0] w_mask;
    logic             w_match;

    assign w_len_legal   = (len_in >= LEN_W'(2));
    assign w_len_clamped = (len_in > PAT_LEN) ? PAT_LEN : len_in;

    // Stream handshake: data is taken on a rising edge only when valid=1, the
    // matcher is in RUN and no load is pending; there is no back-pressure.
    assign w_consume   = (r_state == RUN) && valid && !load;
    assign w_hist_next = {r_hist[PAT_W-2:0], data};
    assign w_fill_inc  = (r_fill == PAT_LEN) ? r_fill : r_fill + LEN_W'(1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_match = w_consume && (w_fill_inc >= r_len) &&
                     (((w_hist_next ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (load) begin
            w_state_next = w_len_legal ? RUN : IDLE;
        end
    end

    // A non-overlapping match only zeroes fill; stale history bits stay masked by it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat  <= '0;
            r_len  <= '0;
            r_hist <= '0;
            r_fill <= '0;
            r_flag <= 1'b0;
        end else if (load) begin
            r_pat  <= pat_in;
            r_len  <= w_len_clamped;
            r_hist <= '0;
            r_fill <= '0;
            r_flag <= 1'b0;
        end else begin
            r_flag <= w_match;
            if (w_consume) begin
                r_hist <= w_hist_next;
                r_fill <= (w_match && !overlap) ? '0 : w_fill_inc;
            end
        end
    end

    pat_match_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_match),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );

    assign armed = (r_state == RUN);
    assign flag  = r_flag;

endmodule

// File: tb/tb_pat_match.sv
// Bench for pat_match: directed scenarios plus random traffic, scored per cycle
// against a bit-list reference model.
module tb_pat_match;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W) + 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic [LEN_W-1:0] len_in = '0;
    logic             valid = 1'b0;
    logic             data = 1'b0;
    logic             overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             armed;
    logic             flag;
    logic [CNT_W-1:0] match_cnt;

    pat_match #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .pat_in   (pat_in),
        .len_in   (len_in),
        .valid    (valid),
        .data     (data),
        .overlap  (overlap),
        .cnt_clr  (cnt_clr),
        .armed    (armed),
        .flag     (flag),
        .match_cnt(match_cnt)
    );

    // scoreboard: {armed, flag, match_cnt} expected after each edge
    logic [CNT_W+1:0] exp_q[$];
    string            tag_q[$];
    int               n_tests = 0;
    int               n_fail = 0;
    string            cur_tag = "reset";

    // reference model: consumed bits since the last restart, oldest first
    logic             m_armed = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [PAT_W-1:0] m_pat = '0;
    int               m_len = 0;
    logic             m_bits[$];

    task automatic model_step(input logic ld, input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                              input logic v, input logic d, input logic ov, input logic clr,
                              input logic rst);
        logic hit;
        int   sz;
        hit = 1'b0;
        if (rst) begin
            m_armed = 1'b0;
            m_cnt   = '0;
            m_pat   = '0;
            m_len   = 0;
            m_bits.delete();
        end else begin
            if (ld) begin
                m_pat   = p;
                m_len   = (int'(l) > PAT_W) ? PAT_W : int'(l);
                m_armed = (int'(l) >= 2);
                m_bits.delete();
            end else if (m_armed && v) begin
                m_bits.push_back(d);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                sz = m_bits.size();
                if (sz >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[sz-m_len+k] != m_pat[m_len-1-k]) hit = 1'b0;
                end
                if (hit && !ov) m_bits.delete();
            end
            if (clr) m_cnt = hit ? CNT_W'(1) : '0;
            else if (hit && (m_cnt != '1)) m_cnt = m_cnt + CNT_W'(1);
        end
        exp_q.push_back({m_armed, hit, m_cnt});
        tag_q.push_back(cur_tag);
    endtask

    // driver
    task automatic step(input logic ld, input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic v, input logic d, input logic ov, input logic clr,
                        input logic rst);
        reset   = rst;
        load    = ld;
        pat_in  = p;
        len_in  = l;
        valid   = v;
        data    = d;
        overlap = ov;
        cnt_clr = clr;
        model_step(ld, p, l, v, d, ov, clr, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
        step(1'b1, p, l, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // streams seq[n-1] first
    task automatic feed(input logic [15:0] seq, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) step(1'b0, '0, '0, 1'b1, seq[i], ov, 1'b0, 1'b0);
    endtask

    // monitor: samples outputs 2 time units after each edge
    logic [CNT_W+1:0] mon_got;
    logic [CNT_W+1:0] mon_exp;
    string            mon_tag;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_got = {armed, flag, match_cnt};
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            n_tests++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: {armed,flag,cnt} got %b expected %b at %0t",
                         mon_tag, mon_got, mon_exp, $time);
            end
        end
    end

    initial begin
        logic [LEN_W-1:0] rl;
        int               wait_cyc;

        cur_tag = "reset";
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        cur_tag = "idle_ignores";
        feed(16'hFFFF, 4, 1'b1);

        cur_tag = "seven_bit";
        do_load(8'h1B, 4'd7);
        feed(16'b0011011, 7, 1'b1);
        idle(2);

        cur_tag = "ovl_on";
        do_clr();
        do_load(8'h05, 4'd3);
        feed(16'b10101, 5, 1'b1);
        idle(1);
        cur_tag = "ovl_off";
        do_clr();
        do_load(8'h05, 4'd3);
        feed(16'b10101, 5, 1'b0);
        idle(1);

        cur_tag = "saturate";
        do_clr();
        do_load(8'h03, 4'd2);
        feed(16'hFF, 8, 1'b1);
        cur_tag = "clr_on_match";
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        cur_tag = "mid_reset";
        do_load(8'h1B, 4'd7);
        feed(16'b001101, 6, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        feed(16'b1, 1, 1'b1);
        idle(1);

        cur_tag = "load_with_valid";
        do_load(8'h1B, 4'd7);
        feed(16'b001101, 6, 1'b1);
        step(1'b1, 8'h1B, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        feed(16'b1, 1, 1'b1);

        cur_tag = "len_zero";
        do_load(8'h03, 4'd0);
        feed(16'hFF, 4, 1'b1);

        cur_tag = "len_clamp";
        do_load(8'hA5, 4'd11);
        feed(16'h00A5, 8, 1'b1);
        feed(16'h00A5, 7, 1'b0);
        idle(1);

        cur_tag = "random";
        do_load(8'h02, 4'd2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1'b0, '0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'b0, 1'b0, 1'b1);
            end else if ($urandom_range(0, 39) == 0) begin
                rl = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 11))
                                                 : LEN_W'($urandom_range(2, 4));
                step(1'b1, PAT_W'($urandom), rl, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 49) == 0), 1'b0);
            end else begin
                step(1'b0, PAT_W'($urandom), LEN_W'($urandom), ($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 49) == 0), 1'b0);
            end
        end
        idle(2);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #5;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected samples never checked, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
